// File: rtl/pll_phase_step_ctrl.sv
// pll_phase_step_ctrl: splits signed phase-step requests into IOPLL dynamic phase-shift bursts,
// runs the phase_en/phase_done handshake and tracks a running offset per output counter.
module pll_phase_step_ctrl #(
  parameter int N_CNT    = 5,
  parameter int CNTSEL_W = 5,
  parameter int NUMPS_W  = 3,
  parameter int STEP_W   = 16,
  parameter int EN_LEN   = 2,
  parameter int TIMEOUT  = 1023
) (
  input  logic                scanclk,
  input  logic                rst,
  input  logic                locked,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [CNTSEL_W-1:0] req_cnt,
  input  logic [STEP_W-1:0]   req_steps,
  output logic                done_valid,
  output logic                done_err,
  output logic [1:0]          err_code,
  output logic                busy,
  output logic [CNTSEL_W-1:0] cntsel,
  output logic [NUMPS_W-1:0]  num_phase_shifts,
  output logic                updn,
  output logic                phase_en,
  input  logic                phase_done,
  input  logic [CNTSEL_W-1:0] rd_cnt,
  output logic [STEP_W-1:0]   rd_offset
);
  localparam int TW = $clog2((TIMEOUT > EN_LEN ? TIMEOUT : EN_LEN) + 1);
  localparam int IW = N_CNT > 1 ? $clog2(N_CNT) : 1;
  localparam logic [CNTSEL_W:0] CNT_LIM = (CNTSEL_W + 1)'(N_CNT);
  localparam logic [STEP_W-1:0] MAX_B = STEP_W'((1 << NUMPS_W) - 1);
  localparam logic [TW-1:0] EN_LAST = TW'(EN_LEN - 1);
  localparam logic [TW-1:0] TMO = TW'(TIMEOUT);
  typedef enum logic [2:0] {IDLE, CHECK, LOAD, PULSE, WAIT_LO, WAIT_HI, NEXT, DONE} state_t;
  state_t state;
  logic [1:0] lock_sync, pd_sync;
  logic [CNTSEL_W-1:0] cnt_q;
  logic dir_q;
  logic [STEP_W-1:0] remaining, req_mag, rem_after;
  logic [TW-1:0] tmr;
  logic [STEP_W-1:0] offs [N_CNT];
  logic lock_s, pd_s, in_burst;
  logic [IW-1:0] cnt_idx, rd_idx;
  function automatic logic [NUMPS_W-1:0] clip(input logic [STEP_W-1:0] r);
    return r > MAX_B ? MAX_B[NUMPS_W-1:0] : r[NUMPS_W-1:0];
  endfunction
  assign lock_s    = lock_sync[1];
  assign pd_s      = pd_sync[1];
  assign req_ready = state == IDLE;
  assign busy      = state != IDLE;
  assign in_burst  = state inside {LOAD, PULSE, WAIT_LO, WAIT_HI};
  // Unsigned magnitude so the most-negative request is representable.
  assign req_mag   = req_steps[STEP_W-1] ? ~req_steps + 1'b1 : req_steps;
  assign rem_after = remaining - STEP_W'(num_phase_shifts);
  assign cnt_idx   = cnt_q[IW-1:0];
  assign rd_idx    = rd_cnt[IW-1:0];
  always_ff @(posedge scanclk or posedge rst)
    if (rst) begin
      state            <= IDLE;
      lock_sync        <= '0;
      pd_sync          <= '0;
      cnt_q            <= '0;
      dir_q            <= 1'b0;
      remaining        <= '0;
      tmr              <= '0;
      phase_en         <= 1'b0;
      done_valid       <= 1'b0;
      done_err         <= 1'b0;
      err_code         <= 2'd0;
      cntsel           <= '0;
      num_phase_shifts <= '0;
      updn             <= 1'b0;
      for (int i = 0; i < N_CNT; i++) offs[i] <= '0;
    end else begin
      lock_sync  <= {lock_sync[0], locked};
      pd_sync    <= {pd_sync[0], phase_done};
      done_valid <= 1'b0;
      done_err   <= 1'b0;
      tmr        <= tmr + 1'b1;
      if (in_burst && !lock_s) begin
        phase_en <= 1'b0;
        state <= DONE; done_valid <= 1'b1; done_err <= 1'b1; err_code <= 2'd2;
      end else
        case (state)
          IDLE:
            if (req_valid) begin
              cnt_q     <= req_cnt;
              dir_q     <= ~req_steps[STEP_W-1];
              remaining <= req_mag;
              state     <= CHECK;
            end
          CHECK:
            if ({1'b0, cnt_q} >= CNT_LIM) begin
              state <= DONE; done_valid <= 1'b1; done_err <= 1'b1; err_code <= 2'd1;
            end else if (!lock_s) begin
              state <= DONE; done_valid <= 1'b1; done_err <= 1'b1; err_code <= 2'd2;
            end else if (remaining == '0) begin
              state <= DONE; done_valid <= 1'b1; err_code <= 2'd0;
            end else begin
              // Drive the PLL selectors one cycle ahead of phase_en for setup.
              cntsel           <= cnt_q;
              updn             <= dir_q;
              num_phase_shifts <= clip(remaining);
              state            <= LOAD;
            end
          LOAD: begin
            phase_en <= 1'b1;
            tmr      <= '0;
            state    <= PULSE;
          end
          PULSE:
            if (tmr == EN_LAST) begin
              phase_en <= 1'b0;
              tmr      <= '0;
              state    <= WAIT_LO;
            end
          WAIT_LO:
            if (!pd_s) begin
              tmr   <= '0;
              state <= WAIT_HI;
            end else if (tmr == TMO) begin
              state <= DONE; done_valid <= 1'b1; done_err <= 1'b1; err_code <= 2'd3;
            end
          WAIT_HI:
            if (pd_s) state <= NEXT;
            else if (tmr == TMO) begin
              state <= DONE; done_valid <= 1'b1; done_err <= 1'b1; err_code <= 2'd3;
            end
          NEXT: begin
            offs[cnt_idx] <= dir_q ? offs[cnt_idx] + STEP_W'(num_phase_shifts)
                                   : offs[cnt_idx] - STEP_W'(num_phase_shifts);
            remaining <= rem_after;
            if (rem_after == '0) begin
              state <= DONE; done_valid <= 1'b1; err_code <= 2'd0;
            end else begin
              num_phase_shifts <= clip(rem_after);
              state            <= LOAD;
            end
          end
          DONE: state <= IDLE;
        endcase
    end
  always_ff @(posedge scanclk or posedge rst)
    if (rst) rd_offset <= '0;
    else rd_offset <= ({1'b0, rd_cnt} < CNT_LIM) ? offs[rd_idx] : '0;
endmodule

// File: tb/tb_pll_phase_step_ctrl.sv
// tb_pll_phase_step_ctrl: directed plus randomized checks of pll_phase_step_ctrl against
// a request-level model (burst split, per-counter offsets) and a simple IOPLL responder.
module tb_pll_phase_step_ctrl;
  localparam int EN_LEN = 2;
  localparam int TIMEOUT = 1023;
  logic scanclk = 1'b0, rst, locked, req_valid, req_ready, done_valid, done_err, busy;
  logic updn, phase_en, phase_done;
  logic [4:0] req_cnt, cntsel, rd_cnt;
  logic [15:0] req_steps, rd_offset;
  logic [1:0] err_code;
  logic [2:0] num_phase_shifts;
  logic pll_hang;
  int total = 0, bad = 0, en_cycles = 0;
  logic [15:0] m_off [8];
  typedef struct {logic [4:0] cs; logic [2:0] nps; logic ud; logic [8:0] pre;} burst_t;
  burst_t q[$];
  logic prev_en = 1'b0;
  logic [8:0] prev_drv = '0;

  pll_phase_step_ctrl dut (
    .scanclk(scanclk), .rst(rst), .locked(locked), .req_valid(req_valid), .req_ready(req_ready),
    .req_cnt(req_cnt), .req_steps(req_steps), .done_valid(done_valid), .done_err(done_err),
    .err_code(err_code), .busy(busy), .cntsel(cntsel), .num_phase_shifts(num_phase_shifts),
    .updn(updn), .phase_en(phase_en), .phase_done(phase_done), .rd_cnt(rd_cnt), .rd_offset(rd_offset)
  );

  always #5 scanclk = ~scanclk;

  // IOPLL responder: phase_done falls 3 cycles after phase_en rises and recovers 10 later.
  initial begin
    phase_done = 1'b1;
    forever begin
      @(posedge phase_en);
      if (!pll_hang) begin
        repeat (3) @(posedge scanclk);
        #1 phase_done = 1'b0;
        repeat (10) @(posedge scanclk);
        #1 phase_done = 1'b1;
      end
    end
  end

  // Burst monitor: snapshot PLL selectors at each phase_en rise and one cycle before it.
  always @(negedge scanclk) begin
    if (phase_en && !prev_en) q.push_back('{cntsel, num_phase_shifts, updn, prev_drv});
    if (phase_en) en_cycles++;
    prev_en = phase_en;
    prev_drv = {cntsel, num_phase_shifts, updn};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic do_req(input int c, input int s, output int ec, output int de, output int lat);
    int n = 0;
    while (!req_ready && n < 100) begin @(negedge scanclk); n++; end
    chk("ready_before_req", 32'(req_ready), 1);
    req_cnt = c[4:0];
    req_steps = s[15:0];
    req_valid = 1'b1;
    @(posedge scanclk);
    #1 req_valid = 1'b0;
    lat = 0; ec = -1; de = -1;
    for (int i = 1; i <= 3000; i++) begin
      @(negedge scanclk);
      if (done_valid) begin lat = i; ec = int'(err_code); de = int'(done_err); break; end
    end
    chk("done_seen", 32'(lat != 0), 1);
    @(negedge scanclk);
    chk("done_one_cycle", 32'(done_valid), 0);
    chk("ready_after_done", 32'(req_ready), 1);
  endtask

  // Request-level reference: error priority, 7-step burst split, offset += steps on success.
  task automatic run(input int c, input int s);
    int ec, de, lat, mag, exp_ec, nb, q0, e0, b;
    logic [15:0] s16;
    s16 = s[15:0];
    mag = s < 0 ? -s : s;
    exp_ec = c >= 5 ? 1 : (!locked ? 2 : 0);
    nb = exp_ec == 0 ? (mag + 6) / 7 : 0;
    q0 = q.size();
    e0 = en_cycles;
    do_req(c, s, ec, de, lat);
    chk("err_code", ec, exp_ec);
    chk("done_err", de, int'(exp_ec != 0));
    chk("burst_count", q.size() - q0, nb);
    chk("phase_en_cycles", en_cycles - e0, nb * EN_LEN);
    for (int i = 0; i < nb && q0 + i < q.size(); i++) begin
      b = mag - 7 * i > 7 ? 7 : mag - 7 * i;
      chk("burst_nps", 32'(q[q0+i].nps), b);
      chk("burst_updn", 32'(q[q0+i].ud), int'(s > 0));
      chk("burst_cntsel", 32'(q[q0+i].cs), c);
      chk("burst_setup", 32'(q[q0+i].pre), 32'({q[q0+i].cs, q[q0+i].nps, q[q0+i].ud}));
    end
    if (s == 0 && exp_ec == 0) chk("zero_step_latency", lat, 2);
    if (exp_ec == 0) m_off[c] = m_off[c] + s16;
  endtask

  task automatic rd_chk(input int i, input logic [15:0] e);
    rd_cnt = i[4:0];
    @(negedge scanclk);
    chk($sformatf("rd_offset[%0d]", i), 32'(rd_offset), 32'(e));
  endtask

  initial begin
    int ec, de, lat, q0, n, c, s;
    logic dv;
    rst = 1'b1; locked = 1'b1; req_valid = 1'b0; req_cnt = '0; req_steps = '0; rd_cnt = '0;
    pll_hang = 1'b0;
    for (int i = 0; i < 8; i++) m_off[i] = '0;
    repeat (3) @(negedge scanclk);
    chk("rst_phase_en", 32'(phase_en), 0);
    chk("rst_done_valid", 32'(done_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_pll_drive", 32'({cntsel, num_phase_shifts, updn, err_code}), 0);
    chk("rst_rd_offset", 32'(rd_offset), 0);
    rst = 1'b0;
    repeat (3) @(negedge scanclk);
    // Single burst, multi-burst retard, return to zero.
    run(2, 5);   rd_chk(2, 16'd5);
    run(1, -20); rd_chk(1, 16'hFFEC);
    run(1, 20);  rd_chk(1, 16'd0);
    // Zero step and bad index.
    run(3, 0);
    run(5, 4);
    run(7, -9);
    // phase_done never falls: timeout in WAIT_LO, offset unchanged.
    pll_hang = 1'b1;
    q0 = q.size();
    do_req(0, 3, ec, de, lat);
    chk("timeout_err_code", ec, 3);
    chk("timeout_done_err", de, 1);
    chk("timeout_latency", lat, 3 + EN_LEN + TIMEOUT + 1);
    chk("timeout_bursts", q.size() - q0, 1);
    rd_chk(0, m_off[0]);
    pll_hang = 1'b0;
    // Unlocked at request time.
    locked = 1'b0;
    repeat (4) @(negedge scanclk);
    run(2, 4);
    locked = 1'b1;
    repeat (4) @(negedge scanclk);
    // Lock lost during the second burst of +15: only the first burst of 7 lands.
    q0 = q.size();
    fork
      do_req(4, 15, ec, de, lat);
      begin
        n = 0;
        while (q.size() < q0 + 2 && n < 500) begin @(negedge scanclk); n++; end
        locked = 1'b0;
      end
    join
    chk("lockloss_err_code", ec, 2);
    chk("lockloss_done_err", de, 1);
    chk("lockloss_bursts", q.size() - q0, 2);
    chk("lockloss_phase_en", 32'(phase_en), 0);
    m_off[4] = m_off[4] + 16'd7;
    rd_chk(4, m_off[4]);
    locked = 1'b1;
    repeat (20) @(negedge scanclk);
    // Randomized requests, occasionally unlocked.
    for (int k = 0; k < 12; k++) begin
      c = int'($urandom_range(0, 6));
      s = int'($urandom_range(0, 80)) - 40;
      locked = $urandom_range(0, 5) != 0;
      repeat (4) @(negedge scanclk);
      run(c, s);
      locked = 1'b1;
      repeat (4) @(negedge scanclk);
    end
    for (int i = 0; i < 8; i++) rd_chk(i, i < 5 ? m_off[i] : 16'd0);
    run(0, 9);
    rd_chk(0, m_off[0]);
    // Reset while phase_en is high: async drop, no completion, offsets cleared.
    req_cnt = 5'd3; req_steps = 16'd10; req_valid = 1'b1;
    @(posedge scanclk);
    #1 req_valid = 1'b0;
    n = 0;
    while (!phase_en && n < 50) begin @(negedge scanclk); n++; end
    chk("pulse_before_rst", 32'(phase_en), 1);
    #2 rst = 1'b1;
    #1 chk("rst_async_phase_en", 32'(phase_en), 0);
    dv = 1'b0;
    repeat (3) begin @(negedge scanclk); dv = dv | done_valid; end
    rst = 1'b0;
    repeat (20) begin @(negedge scanclk); dv = dv | done_valid; end
    chk("no_done_after_rst", 32'(dv), 0);
    chk("ready_after_rst", 32'(req_ready), 1);
    for (int i = 0; i < 8; i++) m_off[i] = '0;
    for (int i = 0; i < 5; i++) rd_chk(i, 16'd0);
    run(2, 5);
    rd_chk(2, 16'd5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pll_phase_step_ctrl.md
Name: pll_phase_step_ctrl

Overview:
- Sequencer for the dynamic phase-shift port of an Arria10 IOPLL: scanclk, rst, cntsel, num_phase_shifts, updn, phase_en, phase_done, locked.
- Accepts a signed step request for one PLL output counter and splits it into bursts the PLL port can take.
- Runs the phase_en/phase_done handshake for each burst, with timeout and lock supervision.
- Keeps a running phase offset per counter for software readback; sits between the timing-control register bank and the PLL.

Parameters:
- N_CNT, 5, number of PLL output counters tracked (indices 0..N_CNT-1)
- CNTSEL_W, 5, width of cntsel / req_cnt / rd_cnt
- NUMPS_W, 3, width of num_phase_shifts; maximum burst = 2^NUMPS_W-1
- STEP_W, 16, width of signed request and of offset accumulators
- EN_LEN, 2, phase_en high time in scanclk cycles (>=1)
- TIMEOUT, 1023, max scanclk cycles waiting per phase_done edge

Ports:
- scanclk  in  1  sole clock
- rst  in  1  asynchronous, active-high reset
- locked  in  1  PLL lock, asynchronous; 2-FF synchronised internally
- req_valid  in  1  request valid
- req_ready  out  1  high only in IDLE
- req_cnt  in  CNTSEL_W  target counter index
- req_steps  in  STEP_W  signed step count; >0 = updn=1 (advance), <0 = updn=0
- done_valid  out  1  one-cycle completion pulse
- done_err  out  1  valid with done_valid; 1 = aborted
- err_code  out  2  valid with done_valid: 0 ok, 1 bad index, 2 unlocked, 3 timeout
- busy  out  1  high when not IDLE
- cntsel  out  CNTSEL_W  to PLL; held stable whole burst
- num_phase_shifts  out  NUMPS_W  to PLL; held stable whole burst
- updn  out  1  to PLL; held stable whole burst
- phase_en  out  1  to PLL
- phase_done  in  1  from PLL, asynchronous; 2-FF synchronised internally
- rd_cnt  in  CNTSEL_W  offset readback index
- rd_offset  out  STEP_W  registered offset of rd_cnt; 1-cycle latency; 0 for index >= N_CNT

Behaviour:
- Reset (async, immediate): state IDLE; phase_en, done_valid, done_err, busy = 0; err_code, cntsel, num_phase_shifts, updn, rd_offset = 0; all offsets = 0; synchronisers cleared. rst during a burst drops phase_en at once; no completion pulse is issued.
- Accept: req_valid & req_ready latches req_cnt and req_steps; remaining = |req_steps|, computed as an unsigned STEP_W magnitude, so the most-negative value is valid.
- FSM states: IDLE, CHECK, LOAD, PULSE, WAIT_LO, WAIT_HI, NEXT, DONE.
- IDLE -> CHECK on accept.
- CHECK:
  - req_cnt >= N_CNT -> DONE, err 1.
  - synced locked = 0 -> DONE, err 2.
  - remaining = 0 -> DONE, ok, with no PLL activity.
  - otherwise -> LOAD.
- LOAD: burst = min(remaining, 2^NUMPS_W-1); drive cntsel, num_phase_shifts = burst, updn. -> PULSE next cycle, giving setup >= 1 cycle before phase_en.
- PULSE: phase_en = 1 for exactly EN_LEN cycles -> WAIT_LO.
- WAIT_LO: wait for synced phase_done = 0 -> WAIT_HI.
- WAIT_HI: wait for synced phase_done = 1 -> NEXT.
- Timeout: each wait state has a counter reset on entry; reaching TIMEOUT -> DONE, err 3.
- Lock loss: synced locked = 0 in any state from LOAD to WAIT_HI -> phase_en = 0 and DONE, err 2.
- NEXT: offset[cnt] += burst (updn = 1) or -= burst (updn = 0), two's-complement wrap mod 2^STEP_W; remaining -= burst. remaining = 0 -> DONE ok, else -> LOAD.
- Partial completion: offsets reflect completed bursts only; an aborted burst is not added.
- DONE: done_valid = 1 for one cycle with done_err and err_code -> IDLE. req_ready returns high the following cycle.
- Drive hold: cntsel, num_phase_shifts and updn keep their last values in IDLE.
- Readback: rd_offset is registered every cycle. If NEXT updates the index being read in cycle t, rd_offset shows the new value at t+2.

Test Plan:
- Reset, then req_cnt=2, steps=+5, PLL model (phase_done low 3 cycles after phase_en, high 10 later) -> one burst, num_phase_shifts=5, updn=1, phase_en high 2 cycles, done ok, rd_offset(2)=5.
- steps=-20 on cnt 1 -> bursts 7,7,6 with updn=0, three phase_en pulses, done ok, offset(1)=-20; then +20 -> offset(1)=0.
- steps=0 -> done_valid 2 cycles after accept, ok, phase_en never high; req_cnt=5 -> err_code 1.
- Model never returns phase_done low -> err_code 3 after TIMEOUT+1 cycles in WAIT_LO; offset unchanged.
- steps=+15, drop locked during the 2nd burst -> phase_en low, err_code 2, offset=+7.
- Assert rst mid-PULSE -> phase_en low asynchronously, no done_valid, all offsets 0, req_ready high after release.
